// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the pipelined carry-lookahead adder.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_GROUP  = 4;
  localparam int DEFAULT_STAGES = 2;

  // Lookahead groups resolved by each pipeline stage; guarded so illegal
  // parameter sets reach the elaboration error instead of a divide-by-zero.
  function automatic int groups_per_stage(input int width, input int group, input int stages);
    if (group < 1 || stages < 1) return 1;
    return (width / group) / stages;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice: sum, carry-out and group generate/propagate.
module cla_group
  import adder_pkg::*;
#(
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_cin,
  output logic [GROUP-1:0] o_sum,
  output logic             o_cout,
  output logic             o_g,
  output logic             o_p
);

  logic [GROUP-1:0] w_gen;
  logic [GROUP-1:0] w_prop;
  logic [GROUP:0]   w_c;

  always_comb begin
    // NOTE: every signal written here gets a value before any conditional use, so no latch is inferred.
    w_gen  = i_a & i_b;
    w_prop = i_a | i_b;
    w_c    = '0;
    w_c[0] = i_cin;
    o_g    = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      w_c[i+1] = w_gen[i] | (w_prop[i] & w_c[i]);
      o_g      = w_gen[i] | (w_prop[i] & o_g);
    end
    o_p    = &w_prop;
    o_sum  = i_a ^ i_b ^ w_c[GROUP-1:0];
    o_cout = w_c[GROUP];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder, valid/ready streaming, latency STAGES.
// Define CLA_OVF_EN to add the signed-overflow output and its operand-MSB registers.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int GROUP  = DEFAULT_GROUP,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int GPS = groups_per_stage(WIDTH, GROUP, STAGES);
  localparam int SW  = GPS * GROUP;

  if (STAGES < 1) begin : g_err_stages
    $error("pipelined_cla_adder: STAGES must be at least 1");
  end else if (GROUP < 1 || WIDTH % GROUP != 0) begin : g_err_group
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end else if ((WIDTH / GROUP) % STAGES != 0) begin : g_err_split
    $error("pipelined_cla_adder: STAGES must divide WIDTH/GROUP");
  end

  logic w_advance;

  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  // Stage s resolves bits [LO, HI); operands above HI and sums below LO ride along.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * SW;
    localparam int HI = LO + SW;

    logic [WIDTH-1:LO] w_a;
    logic [WIDTH-1:LO] w_b;
    logic              w_cin;
    logic              w_vin;
    logic [HI-1:0]     w_next_sum;
    wire  [SW-1:0]     w_ssum;
    logic              r_valid;
    logic              r_carry;
    logic [HI-1:0]     r_sum;

    if (s == 0) begin : g_src
      assign w_a        = a;
      assign w_b        = b;
      assign w_cin      = c_in;
      assign w_vin      = in_valid;
      assign w_next_sum = w_ssum;
    end else begin : g_src
      assign w_a        = g_stage[s-1].g_ops.r_a;
      assign w_b        = g_stage[s-1].g_ops.r_b;
      assign w_cin      = g_stage[s-1].r_carry;
      assign w_vin      = g_stage[s-1].r_valid;
      assign w_next_sum = {w_ssum, g_stage[s-1].r_sum};
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      logic w_gcin;
      logic w_gcout;
      logic w_gg;
      logic w_gp;

      if (j == 0) begin : g_cin
        assign w_gcin = w_cin;
      end else begin : g_cin
        assign w_gcin = g_grp[j-1].w_gcout;
      end

      cla_group #(.GROUP(GROUP)) u_cla (
        .i_a   (w_a[LO + j*GROUP +: GROUP]),
        .i_b   (w_b[LO + j*GROUP +: GROUP]),
        .i_cin (w_gcin),
        .o_sum (w_ssum[j*GROUP +: GROUP]),
        .o_cout(w_gcout),
        .o_g   (w_gg),
        .o_p   (w_gp)
      );

      // The in-group carry chain and the group generate/propagate must agree.
      always_comb begin
        assert (w_gcout == (w_gg | (w_gp & w_gcin)));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state uses non-blocking assignments; data registers are reset too so sum reads 0 under reset.
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_advance) begin
        r_valid <= w_vin;
        r_carry <= g_grp[GPS-1].w_gcout;
        r_sum   <= w_next_sum;
      end
    end

    if (s < STAGES - 1) begin : g_ops
      logic [WIDTH-1:HI] r_a;
      logic [WIDTH-1:HI] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_a[WIDTH-1:HI];
          r_b <= w_b[WIDTH-1:HI];
        end
      end
    end

`ifdef CLA_OVF_EN
    if (s == STAGES - 1) begin : g_msb
      logic r_msb_a;
      logic r_msb_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_msb_a <= 1'b0;
          r_msb_b <= 1'b0;
        end else if (w_advance) begin
          r_msb_a <= w_a[WIDTH-1];
          r_msb_b <= w_b[WIDTH-1];
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign c_out     = g_stage[STAGES-1].r_carry;

`ifdef CLA_OVF_EN
  assign ovf = (g_stage[STAGES-1].g_msb.r_msb_a == g_stage[STAGES-1].g_msb.r_msb_b)
             & (sum[WIDTH-1] != g_stage[STAGES-1].g_msb.r_msb_a);
`endif

endmodule
